display_tx_port: RTL and testbench

//  Memory-mapped display output port for the LC-3 datapath; the write-side counterpart of the input mux path.

---
 rtl/display_tx_port.sv | 173 +++++++++++++++++
 tb/tb_display_tx_port.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_tx_port.sv
// ---------------------------------------------------------------------------
// display_tx_port
//
// Memory-mapped display output port for the LC-3 datapath. A CPU store to
// the display data register (DDR) is serialised onto an 8N1 serial line.
// A store to the display status register (DSR) sets the interrupt-enable
// bit. The DSR value is driven continuously so the input mux can select it
// on loads.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   DDR_ADDR      display data register address
//   DSR_ADDR      display status register address
//
// Ports
//   CLK      in   system clock, rising edge
//   RESET    in   asynchronous active-high reset
//   MAR      in   [15:0] memory address register
//   MDR_IN   in   [15:0] store data
//   MIO_EN   in   memory/IO access strobe
//   R_W      in   1 = write, 0 = read
//   DSR_OUT  out  [15:0] {READY, IE, 14'b0}
//   DSR_INT  out  READY & IE, level interrupt request
//   TX       out  serial line, idle high
//   BUSY     out  ~READY
// ---------------------------------------------------------------------------
module display_tx_port #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [15:0] DDR_ADDR     = 16'hFE06,
    parameter logic [15:0] DSR_ADDR     = 16'hFE04
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR_IN,
    input  logic        MIO_EN,
    input  logic        R_W,
    output logic [15:0] DSR_OUT,
    output logic        DSR_INT,
    output logic        TX,
    output logic        BUSY
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic                ie_q, ie_d;
    logic                tx_q, tx_d;
    logic [7:0]          ddr_q, ddr_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          idx_q, idx_d;

    logic                wr_ddr;
    logic                wr_dsr;
    logic                accept;
    logic                baud_wrap;
    logic [2:0]          idx_nxt;

    // Store data bits that this port never looks at.
    logic                unused_mdr;
    assign unused_mdr = ^{MDR_IN[15], MDR_IN[13:8]};

    // Write decode; the two addresses differ so at most one strobe fires.
    assign wr_ddr = MIO_EN & R_W & (MAR == DDR_ADDR);
    assign wr_dsr = MIO_EN & R_W & (MAR == DSR_ADDR);

    // A DDR store is only taken while the transmitter is ready. A store
    // landing on the completion edge still sees READY=0 and is dropped.
    assign accept    = wr_ddr & ready_q;
    assign baud_wrap = (baud_q == BAUD_LAST);
    assign idx_nxt   = idx_q + 3'd1;

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        ie_d    = ie_q;
        tx_d    = tx_q;
        ddr_d   = ddr_q;
        idx_d   = idx_q;

        // Baud counter free-runs while a frame is in flight and is held at
        // zero in IDLE so every frame starts with a full-length start bit.
        if ((state_q == S_IDLE) || baud_wrap) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + BAUD_W'(1);
        end

        // IE is writable at any time, including mid-frame.
        if (wr_dsr) begin
            ie_d = MDR_IN[14];
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    ddr_d   = MDR_IN[7:0];
                    ready_d = 1'b0;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    idx_d   = 3'd0;
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    state_d = S_DATA;
                    idx_d   = 3'd0;
                    tx_d    = ddr_q[0];
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_nxt;
                        tx_d  = ddr_q[idx_nxt];
                    end
                end
            end
            S_STOP: begin
                if (baud_wrap) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Reset abandons any frame in flight immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            ie_q    <= 1'b0;
            tx_q    <= 1'b1;
            ddr_q   <= 8'h00;
            baud_q  <= '0;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            ie_q    <= ie_d;
            tx_q    <= tx_d;
            ddr_q   <= ddr_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
        end
    end

    assign DSR_OUT = {ready_q, ie_q, 14'b0};
    assign DSR_INT = ready_q & ie_q;
    assign TX      = tx_q;
    assign BUSY    = ~ready_q;

endmodule

// File: tb/tb_display_tx_port.sv
module tb_display_tx_port;

    localparam int CPB = 4;
    localparam logic [15:0] DDR = 16'hFE06;
    localparam logic [15:0] DSR = 16'hFE04;

    logic        CLK;
    logic        RESET;
    logic [15:0] MAR;
    logic [15:0] MDR_IN;
    logic        MIO_EN;
    logic        R_W;
    logic [15:0] DSR_OUT;
    logic        DSR_INT;
    logic        TX;
    logic        BUSY;

    int errors = 0;
    int checks = 0;

    // Scoreboard: bytes expected on the serial line, in order.
    logic [7:0] exp_q[$];

    display_tx_port #(.CLKS_PER_BIT(CPB)) dut (
        .CLK(CLK), .RESET(RESET), .MAR(MAR), .MDR_IN(MDR_IN),
        .MIO_EN(MIO_EN), .R_W(R_W), .DSR_OUT(DSR_OUT), .DSR_INT(DSR_INT),
        .TX(TX), .BUSY(BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    // One bus cycle; returns 1ns after the edge that sampled it.
    task automatic write_bus(input logic [15:0] addr, input logic [15:0] data,
                             input logic mio, input logic rw);
        @(negedge CLK);
        MAR = addr; MDR_IN = data; MIO_EN = mio; R_W = rw;
        @(posedge CLK);
        #1;
        MIO_EN = 1'b0; R_W = 1'b0;
    endtask

    // Called 1ns after accepting edge k. Samples each bit mid-cell and
    // records status at k+1, k+39, k+40. Optionally issues one store that
    // is sampled at edge k+inj_at.
    task automatic capture(input int inj_at, input logic [15:0] inj_addr,
                           input logic [15:0] inj_data, output logic [9:0] obs,
                           output logic [15:0] dsr1, output logic [15:0] dsr39,
                           output logic [15:0] dsr40, output logic int1,
                           output logic int39, output logic int40);
        obs = '0; dsr1 = '0; dsr39 = '0; dsr40 = '0;
        int1 = 1'b0; int39 = 1'b0; int40 = 1'b0;
        for (int c = 1; c <= 10 * CPB; c++) begin
            @(posedge CLK);
            #1;
            if (c == inj_at) begin
                MIO_EN = 1'b0; R_W = 1'b0;
            end
            if (c % CPB == CPB / 2) obs[c / CPB] = TX;
            if (c == 1)  begin dsr1  = DSR_OUT; int1  = DSR_INT; end
            if (c == 39) begin dsr39 = DSR_OUT; int39 = DSR_INT; end
            if (c == 40) begin dsr40 = DSR_OUT; int40 = DSR_INT; end
            if (c == inj_at - 1) begin
                MAR = inj_addr; MDR_IN = inj_data; MIO_EN = 1'b1; R_W = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; MAR = '0; MDR_IN = '0; MIO_EN = 1'b0; R_W = 1'b0;
        #1;
        checks++;
        if (TX !== 1'b1 || DSR_OUT !== 16'h8000 || DSR_INT !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: TX=%b DSR_OUT=%h INT=%b BUSY=%b want 1/8000/0/0",
                     TX, DSR_OUT, DSR_INT, BUSY);
        end
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            checks++;
            if (TX !== 1'b1 || DSR_OUT !== 16'h8000 || DSR_INT !== 1'b0) begin
                errors++;
                $display("FAIL idle_%0d: TX=%b DSR_OUT=%h INT=%b want 1/8000/0",
                         i, TX, DSR_OUT, DSR_INT);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [9:0] obs; logic [15:0] d1, d39, d40; logic i1, i39, i40;
        logic [7:0] eb;
        exp_q.push_back(8'h41);
        write_bus(DDR, 16'h0041, 1'b1, 1'b1);
        checks++;
        if (DSR_OUT !== 16'h0000 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL t2_busy: DSR_OUT=%h BUSY=%b want 0000/1", DSR_OUT, BUSY);
        end
        capture(0, 16'h0000, 16'h0000, obs, d1, d39, d40, i1, i39, i40);
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL t2_frame: got %b, scoreboard empty", obs);
        end else begin
            eb = exp_q.pop_front();
            if (obs !== frame_of(eb)) begin
                errors++;
                $display("FAIL t2_frame: got %b want %b", obs, frame_of(eb));
            end
        end
        checks++;
        if (d39 !== 16'h0000 || d40 !== 16'h8000) begin
            errors++;
            $display("FAIL t2_ready_timing: dsr@39=%h dsr@40=%h want 0000/8000", d39, d40);
        end
    endtask

    task automatic test_drop_while_busy();
        logic [9:0] obs; logic [15:0] d1, d39, d40; logic i1, i39, i40;
        logic [7:0] eb;
        logic bad;
        // Frame A: x42 arrives 20 cycles into the x41 frame.
        exp_q.push_back(8'h41);
        write_bus(DDR, 16'h0041, 1'b1, 1'b1);
        capture(20, DDR, 16'h0042, obs, d1, d39, d40, i1, i39, i40);
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL t3_frame_a: got %b, scoreboard empty", obs);
        end else begin
            eb = exp_q.pop_front();
            if (obs !== frame_of(eb)) begin
                errors++;
                $display("FAIL t3_frame_a: got %b want %b", obs, frame_of(eb));
            end
        end
        // Frame B: x43 lands on the completion edge.
        exp_q.push_back(8'h96);
        write_bus(DDR, 16'hAB96, 1'b1, 1'b1);
        capture(40, DDR, 16'h0043, obs, d1, d39, d40, i1, i39, i40);
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL t3_frame_b: got %b, scoreboard empty", obs);
        end else begin
            eb = exp_q.pop_front();
            if (obs !== frame_of(eb)) begin
                errors++;
                $display("FAIL t3_frame_b: got %b want %b", obs, frame_of(eb));
            end
        end
        checks++;
        if (d40 !== 16'h8000) begin
            errors++;
            $display("FAIL t3_completion_drop: dsr@40=%h want 8000", d40);
        end
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK);
            #1;
            if (TX !== 1'b1 || DSR_OUT !== 16'h8000) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL t3_after_drop: line activity seen, TX=%b DSR_OUT=%h want 1/8000",
                     TX, DSR_OUT);
        end
    endtask

    task automatic test_interrupt();
        logic [9:0] obs; logic [15:0] d1, d39, d40; logic i1, i39, i40;
        logic [7:0] eb;
        write_bus(DSR, 16'h4000, 1'b1, 1'b1);
        checks++;
        if (DSR_OUT !== 16'hC000 || DSR_INT !== 1'b1) begin
            errors++;
            $display("FAIL t4_ie_set: DSR_OUT=%h INT=%b want C000/1", DSR_OUT, DSR_INT);
        end
        exp_q.push_back(8'h55);
        write_bus(DDR, 16'h0055, 1'b1, 1'b1);
        capture(0, 16'h0000, 16'h0000, obs, d1, d39, d40, i1, i39, i40);
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL t4_frame: got %b, scoreboard empty", obs);
        end else begin
            eb = exp_q.pop_front();
            if (obs !== frame_of(eb)) begin
                errors++;
                $display("FAIL t4_frame: got %b want %b", obs, frame_of(eb));
            end
        end
        checks++;
        if (i1 !== 1'b0 || i39 !== 1'b0 || d39 !== 16'h4000 || i40 !== 1'b1 || d40 !== 16'hC000) begin
            errors++;
            $display("FAIL t4_int_window: int@1=%b int@39=%b dsr@39=%h int@40=%b dsr@40=%h want 0/0/4000/1/C000",
                     i1, i39, d39, i40, d40);
        end
        // Clearing IE mid-frame must leave the frame intact.
        exp_q.push_back(8'hA5);
        write_bus(DDR, 16'h00A5, 1'b1, 1'b1);
        capture(20, DSR, 16'h0000, obs, d1, d39, d40, i1, i39, i40);
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL t4_frame_ie_clr: got %b, scoreboard empty", obs);
        end else begin
            eb = exp_q.pop_front();
            if (obs !== frame_of(eb)) begin
                errors++;
                $display("FAIL t4_frame_ie_clr: got %b want %b", obs, frame_of(eb));
            end
        end
        checks++;
        if (d40 !== 16'h8000 || i40 !== 1'b0) begin
            errors++;
            $display("FAIL t4_ie_clr_mid: dsr@40=%h int@40=%b want 8000/0", d40, i40);
        end
        // READY is not writable through the DSR.
        write_bus(DSR, 16'h7FFF, 1'b1, 1'b1);
        checks++;
        if (DSR_OUT !== 16'hC000) begin
            errors++;
            $display("FAIL t4_ready_ro: DSR_OUT=%h want C000", DSR_OUT);
        end
        write_bus(DSR, 16'h8000, 1'b1, 1'b1);
        checks++;
        if (DSR_OUT !== 16'h8000 || DSR_INT !== 1'b0) begin
            errors++;
            $display("FAIL t4_ie_clr: DSR_OUT=%h INT=%b want 8000/0", DSR_OUT, DSR_INT);
        end
    endtask

    task automatic test_async_reset();
        logic [9:0] obs; logic [15:0] d1, d39, d40; logic i1, i39, i40;
        logic [7:0] eb;
        // Reset during the start bit, where TX is low.
        write_bus(DSR, 16'h4000, 1'b1, 1'b1);
        write_bus(DDR, 16'h00FF, 1'b1, 1'b1);
        @(posedge CLK);
        #1;
        checks++;
        if (TX !== 1'b0) begin
            errors++; $display("FAIL t5_start_low: TX=%b want 0", TX);
        end
        #2 RESET = 1'b1;
        #1;
        checks++;
        if (TX !== 1'b1 || DSR_OUT !== 16'h8000 || DSR_INT !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL t5_reset_start: TX=%b DSR_OUT=%h INT=%b BUSY=%b want 1/8000/0/0",
                     TX, DSR_OUT, DSR_INT, BUSY);
        end
        @(negedge CLK);
        RESET = 1'b0;
        // Reset at cycle 15 of an x00FF frame with IE set.
        write_bus(DSR, 16'h4000, 1'b1, 1'b1);
        write_bus(DDR, 16'h00FF, 1'b1, 1'b1);
        repeat (14) @(posedge CLK);
        #1;
        checks++;
        if (DSR_OUT !== 16'h4000) begin
            errors++; $display("FAIL t5_busy_before: DSR_OUT=%h want 4000", DSR_OUT);
        end
        #1 RESET = 1'b1;
        #1;
        checks++;
        if (TX !== 1'b1 || DSR_OUT !== 16'h8000 || DSR_INT !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL t5_reset_mid: TX=%b DSR_OUT=%h INT=%b BUSY=%b want 1/8000/0/0",
                     TX, DSR_OUT, DSR_INT, BUSY);
        end
        @(negedge CLK);
        RESET = 1'b0;
        exp_q.push_back(8'h3C);
        write_bus(DDR, 16'h003C, 1'b1, 1'b1);
        capture(0, 16'h0000, 16'h0000, obs, d1, d39, d40, i1, i39, i40);
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL t5_clean_frame: got %b, scoreboard empty", obs);
        end else begin
            eb = exp_q.pop_front();
            if (obs !== frame_of(eb)) begin
                errors++;
                $display("FAIL t5_clean_frame: got %b want %b", obs, frame_of(eb));
            end
        end
        checks++;
        if (d1 !== 16'h0000 || d40 !== 16'h8000) begin
            errors++;
            $display("FAIL t5_clean_status: dsr@1=%h dsr@40=%h want 0000/8000", d1, d40);
        end
    endtask

    task automatic test_decode();
        logic [15:0] addr_t[4] = '{DDR, DDR, 16'hFE08, DSR};
        logic [15:0] data_t[4] = '{16'h0041, 16'h0041, 16'h0041, 16'h4000};
        logic        mio_t[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic        rw_t[4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic        bad;
        for (int n = 0; n < 4; n++) begin
            write_bus(addr_t[n], data_t[n], mio_t[n], rw_t[n]);
            bad = 1'b0;
            for (int i = 0; i < 6; i++) begin
                if (TX !== 1'b1 || DSR_OUT !== 16'h8000) bad = 1'b1;
                @(posedge CLK);
                #1;
            end
            checks++;
            if (bad !== 1'b0) begin
                errors++;
                $display("FAIL t6_decode_%0d: TX=%b DSR_OUT=%h want 1/8000", n, TX, DSR_OUT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_drop_while_busy();
        test_interrupt();
        test_async_reset();
        test_decode();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
